// File: rtl/vram_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vram_arbiter_pkg : shared tag encoding and default widths.   Rev 1.0
// ---------------------------------------------------------------------------
package vram_arbiter_pkg;

  localparam int unsigned C_DEF_AW = 12;
  localparam int unsigned C_DEF_DW = 8;

  // Owner of the RAM slot travelling alongside the read data.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_e;

endpackage
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vram_arbiter : VGA-priority arbiter for a single-port text VRAM with a
//                starvation bound and a 1-entry posted CPU write buffer. Rev 1.0
// ---------------------------------------------------------------------------
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned AW         = C_DEF_AW,
  parameter int unsigned DW         = C_DEF_DW,
  parameter int unsigned STARVE_MAX = 7,
  parameter int unsigned RAM_LAT    = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_valid,
  output logic [DW-1:0] vga_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  localparam int unsigned   SW           = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);

  logic          wb_valid_q,   wb_valid_d;
  logic [AW-1:0] wb_addr_q,    wb_addr_d;
  logic [DW-1:0] wb_data_q,    wb_data_d;
  logic          rd_pending_q, rd_pending_d;
  logic          rd_issued_q,  rd_issued_d;
  logic [AW-1:0] rd_addr_q,    rd_addr_d;
  logic [SW-1:0] starve_q,     starve_d;
  logic [AW-1:0] ram_addr_q,   ram_addr_d;
  logic [DW-1:0] ram_wdata_q,  ram_wdata_d;
  logic          ram_we_q,     ram_we_d;
  logic          wr_ack_q,     wr_ack_d;

  logic cpu_cand_w, gnt_cpu_w, gnt_vga_w, intake_ok_w, wr_take_w, rd_take_w;
  tag_e tag_in_w, tag_out_w;
  tag_e tag_chain_w [RAM_LAT+2];

  // An issued read is no longer a candidate while its data is in flight.
  assign cpu_cand_w  = wb_valid_q | (rd_pending_q & ~rd_issued_q);
  assign gnt_cpu_w   = cpu_cand_w & (~vga_req | (starve_q == C_STARVE_MAX));
  assign gnt_vga_w   = vga_req & ~gnt_cpu_w;
  assign intake_ok_w = cpu_req & ~rd_pending_q & ~cpu_ack & ~wb_valid_q;
  assign wr_take_w   = intake_ok_w & cpu_we;
  assign rd_take_w   = intake_ok_w & ~cpu_we;

  always_comb begin
    wb_valid_d   = wb_valid_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    rd_pending_d = rd_pending_q;
    rd_issued_d  = rd_issued_q;
    rd_addr_d    = rd_addr_q;
    starve_d     = '0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_we_d     = 1'b0;
    wr_ack_d     = wr_take_w;
    tag_in_w     = TAG_NONE;

    if (wr_take_w) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = cpu_addr;
      wb_data_d  = cpu_wdata;
    end
    if (rd_take_w) begin
      rd_pending_d = 1'b1;
      rd_addr_d    = cpu_addr;
    end
    if (tag_out_w == TAG_CPU) begin
      rd_pending_d = 1'b0;
      rd_issued_d  = 1'b0;
    end

    if (gnt_cpu_w) begin
      if (wb_valid_q) begin
        ram_addr_d  = wb_addr_q;
        ram_wdata_d = wb_data_q;
        ram_we_d    = 1'b1;
        wb_valid_d  = 1'b0;
      end else begin
        ram_addr_d  = rd_addr_q;
        rd_issued_d = 1'b1;
        tag_in_w    = TAG_CPU;
      end
    end else if (gnt_vga_w) begin
      ram_addr_d = vga_addr;
      tag_in_w   = TAG_VGA;
      if (cpu_cand_w && (starve_q != C_STARVE_MAX)) begin
        starve_d = starve_q + SW'(1);
      end else if (cpu_cand_w) begin
        starve_d = starve_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      rd_pending_q <= 1'b0;
      rd_issued_q  <= 1'b0;
      rd_addr_q    <= '0;
      starve_q     <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      wr_ack_q     <= 1'b0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      rd_pending_q <= rd_pending_d;
      rd_issued_q  <= rd_issued_d;
      rd_addr_q    <= rd_addr_d;
      starve_q     <= starve_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
      wr_ack_q     <= wr_ack_d;
    end
  end

  // Tag pipe aligned so its last stage coincides with ram_q for that slot.
  assign tag_chain_w[0] = tag_in_w;
  for (genvar i = 0; i <= RAM_LAT; i++) begin : g_tag_pipe
    tag_e stage_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) stage_q <= TAG_NONE;
      else          stage_q <= tag_chain_w[i];
    end
    assign tag_chain_w[i+1] = stage_q;
  end
  assign tag_out_w = tag_chain_w[RAM_LAT+1];

  assign vga_gnt   = gnt_vga_w & reset_n;
  assign vga_valid = (tag_out_w == TAG_VGA);
  assign vga_data  = vga_valid ? ram_q : '0;
  assign cpu_ack   = wr_ack_q | (tag_out_w == TAG_CPU);
  assign cpu_rdata = (tag_out_w == TAG_CPU) ? ram_q : '0;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vram_arbiter : directed scenarios plus a randomized run against a
//                   slot-schedule reference model.                  Rev 1.0
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic          vga_valid;
  logic [DW-1:0] vga_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [4096];
  logic          do_preload;

  vram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_valid(vga_valid), .vga_data(vga_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Single-port RAM, one cycle read latency, preloaded with addr=data.
  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_q <= mem[ram_addr];
  end

  task automatic idle_inputs();
    vga_req = 1'b0; vga_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_inputs();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    do_preload = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vga_req = 1'($urandom); vga_addr = 12'($urandom);
      cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = 12'($urandom); cpu_wdata = 8'($urandom);
      #1;
      checks++;
      if ({vga_gnt, vga_valid, cpu_ack, ram_we} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_ctrl cyc=%0d got gnt/vv/ack/we=%b expected 0000", k,
                 {vga_gnt, vga_valid, cpu_ack, ram_we});
      end
      checks++;
      if ({vga_data, cpu_rdata, ram_addr, ram_wdata} !== '0) begin
        failures++;
        $display("FAIL reset_data cyc=%0d got vd=%h rd=%h ra=%h rw=%h expected 0", k,
                 vga_data, cpu_rdata, ram_addr, ram_wdata);
      end
    end
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    do_preload = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_vga_stream();
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k < 16) begin vga_req = 1'b1; vga_addr = 12'(k); end
      #1;
      checks++;
      if (vga_gnt !== (k < 16)) begin
        failures++;
        $display("FAIL vga_gnt cyc=%0d got=%b expected=%b", k, vga_gnt, (k < 16));
      end
      checks++;
      if (vga_valid !== (k >= 2)) begin
        failures++;
        $display("FAIL vga_valid cyc=%0d got=%b expected=%b", k, vga_valid, (k >= 2));
      end
      if (k >= 2) begin
        checks++;
        if (vga_data !== 8'(k - 2)) begin
          failures++;
          $display("FAIL vga_data cyc=%0d got=%h expected=%h", k, vga_data, 8'(k - 2));
        end
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_cpu_write();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 8'h5A;
      end
      #1;
      checks++;
      if (cpu_ack !== (k == 1)) begin
        failures++;
        $display("FAIL wr_ack cyc=%0d got=%b expected=%b", k, cpu_ack, (k == 1));
      end
      checks++;
      if (ram_we !== (k == 2)) begin
        failures++;
        $display("FAIL wr_we cyc=%0d got=%b expected=%b", k, ram_we, (k == 2));
      end
      if (k == 2) begin
        checks++;
        if ({ram_addr, ram_wdata} !== {12'h010, 8'h5A}) begin
          failures++;
          $display("FAIL wr_bus got addr=%h data=%h expected addr=010 data=5a",
                   ram_addr, ram_wdata);
        end
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      idle_inputs();
      vga_req = 1'b1; vga_addr = 12'(12'h100 + k);
      if (k == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h040; cpu_wdata = 8'h33;
      end
      #1;
      checks++;
      if (vga_gnt !== (k != 8)) begin
        failures++;
        $display("FAIL starve_gnt cyc=%0d got=%b expected=%b", k, vga_gnt, (k != 8));
      end
      checks++;
      if (ram_we !== (k == 9)) begin
        failures++;
        $display("FAIL starve_we cyc=%0d got=%b expected=%b", k, ram_we, (k == 9));
      end
    end
    idle_cycles(3);
  endtask

  task automatic test_raw_order();
    int   wcyc = -1;
    int   rcyc = -1;
    int   ackc = -1;
    logic [7:0] rdat = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      idle_inputs();
      vga_req = 1'b1; vga_addr = 12'(12'h200 + k);
      if (k == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 8'hA5;
      end else if (k >= 2 && ackc < 0) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
      end
      #1;
      if (ram_we && ram_addr == 12'h020 && wcyc < 0) wcyc = k;
      if (!ram_we && ram_addr == 12'h020 && rcyc < 0) rcyc = k;
      if (k >= 2 && cpu_ack && ackc < 0) begin ackc = k; rdat = cpu_rdata; end
    end
    checks++;
    if (wcyc !== 9) begin
      failures++;
      $display("FAIL raw_wr_drain got cyc=%0d expected 9", wcyc);
    end
    checks++;
    if (rcyc !== 18) begin
      failures++;
      $display("FAIL raw_rd_issue got cyc=%0d expected 18", rcyc);
    end
    checks++;
    if (ackc !== 19 || rdat !== 8'hA5) begin
      failures++;
      $display("FAIL raw_rd_ack got cyc=%0d data=%h expected cyc=19 data=a5", ackc, rdat);
    end
    idle_cycles(3);
  endtask

  task automatic test_reset_inflight();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k < 2) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h005; end
      if (k == 2) reset_n = 1'b0;
      if (k == 4) reset_n = 1'b1;
      #1;
      if (k >= 2) begin
        checks++;
        if ({cpu_ack, vga_valid} !== 2'b00) begin
          failures++;
          $display("FAIL inflight_rst cyc=%0d got ack=%b vv=%b expected 0 0", k,
                   cpu_ack, vga_valid);
        end
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_random();
    logic [7:0]  shadow [4096];
    bit          s_vv[8], s_ack[8], s_ackrd[8], s_we[8];
    logic [7:0]  s_vd[8], s_rd[8], s_wdata[8];
    logic [11:0] s_waddr[8];
    bit          m_wb = 0, m_rd_wait = 0, m_rd_busy = 0;
    logic [11:0] m_wb_addr = '0, m_rd_addr = '0;
    logic [7:0]  m_wb_data = '0;
    int          m_starve = 0;
    bit          d_active = 0, d_we = 0;
    logic [11:0] d_addr = '0;
    logic [7:0]  d_data = '0;
    for (int i = 0; i < 4096; i++) shadow[i] = mem[i];
    for (int i = 0; i < 8; i++) begin
      s_vv[i] = 0; s_ack[i] = 0; s_ackrd[i] = 0; s_we[i] = 0;
      s_vd[i] = '0; s_rd[i] = '0; s_wdata[i] = '0; s_waddr[i] = '0;
    end
    for (int k = 0; k < 2000; k++) begin
      int idx, n1, n2;
      bit ack_now, cand, g_cpu, g_vga, take;
      idx = k % 8; n1 = (k + 1) % 8; n2 = (k + 2) % 8;
      ack_now = s_ack[idx];
      @(negedge clk);
      if (ack_now) begin
        d_active = 0;
        cpu_req = 1'($urandom); cpu_we = 1'($urandom);
        cpu_addr = 12'($urandom_range(0, 31)); cpu_wdata = 8'($urandom);
      end else begin
        if (!d_active && $urandom_range(0, 2) == 0) begin
          d_active = 1; d_we = 1'($urandom);
          d_addr = 12'($urandom_range(0, 31)); d_data = 8'($urandom);
        end
        cpu_req = d_active; cpu_we = d_we; cpu_addr = d_addr; cpu_wdata = d_data;
      end
      vga_req = ($urandom_range(0, 3) != 0);
      vga_addr = 12'($urandom_range(0, 31));
      #1;
      cand  = m_wb | m_rd_wait;
      g_cpu = cand && (!vga_req || m_starve == 7);
      g_vga = vga_req && !g_cpu;
      checks++;
      if (vga_gnt !== g_vga) begin
        failures++;
        $display("FAIL rnd_gnt cyc=%0d got=%b expected=%b", k, vga_gnt, g_vga);
      end
      checks++;
      if (vga_valid !== s_vv[idx] || (s_vv[idx] && vga_data !== s_vd[idx])) begin
        failures++;
        $display("FAIL rnd_vga cyc=%0d got v=%b d=%h expected v=%b d=%h", k,
                 vga_valid, vga_data, s_vv[idx], s_vd[idx]);
      end
      checks++;
      if (cpu_ack !== s_ack[idx] || (s_ackrd[idx] && cpu_rdata !== s_rd[idx])) begin
        failures++;
        $display("FAIL rnd_cpu cyc=%0d got a=%b d=%h expected a=%b d=%h", k,
                 cpu_ack, cpu_rdata, s_ack[idx], s_rd[idx]);
      end
      checks++;
      if (ram_we !== s_we[idx] ||
          (s_we[idx] && {ram_addr, ram_wdata} !== {s_waddr[idx], s_wdata[idx]})) begin
        failures++;
        $display("FAIL rnd_ram cyc=%0d got we=%b a=%h d=%h expected we=%b a=%h d=%h", k,
                 ram_we, ram_addr, ram_wdata, s_we[idx], s_waddr[idx], s_wdata[idx]);
      end
      take = cpu_req && !ack_now && !m_rd_busy && !m_wb;
      if (g_cpu) begin
        if (m_wb) begin
          s_we[n1] = 1; s_waddr[n1] = m_wb_addr; s_wdata[n1] = m_wb_data;
          shadow[m_wb_addr] = m_wb_data;
          m_wb = 0;
        end else begin
          m_rd_wait = 0;
          s_ack[n2] = 1; s_ackrd[n2] = 1; s_rd[n2] = shadow[m_rd_addr];
        end
        m_starve = 0;
      end else if (g_vga) begin
        s_vv[n2] = 1; s_vd[n2] = shadow[vga_addr];
        m_starve = cand ? ((m_starve < 7) ? m_starve + 1 : 7) : 0;
      end else begin
        m_starve = 0;
      end
      if (s_ackrd[idx]) m_rd_busy = 0;
      if (take) begin
        if (cpu_we) begin
          m_wb = 1; m_wb_addr = cpu_addr; m_wb_data = cpu_wdata; s_ack[n1] = 1;
        end else begin
          m_rd_wait = 1; m_rd_busy = 1; m_rd_addr = cpu_addr;
        end
      end
      s_vv[idx] = 0; s_ack[idx] = 0; s_ackrd[idx] = 0; s_we[idx] = 0;
    end
    idle_cycles(3);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_vga_stream();
    test_cpu_write();
    test_starvation();
    test_raw_order();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
